// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
interface dmem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [2:0]  REQ_FUNCT3;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_FUNCT3, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_FUNCT3, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data memory: one request in flight, IDLE -> ACCESS -> RESP,
// byte/half/word loads and stores with alignment, range and encoding fault checks.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input logic              CLK,
  input logic              RST,
  dmem_responder_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             we_q,        we_d;
  logic [31:0]      addr_q,      addr_d;
  logic [31:0]      wdata_q,     wdata_d;
  logic [2:0]       f3_q,        f3_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic             err_q,       err_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx_c;
  logic [31:0]      word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic             acc_err_c;
  logic [31:0]      ld_data_c;
  logic [3:0]       be_c;
  logic [31:0]      wr_data_c;
  logic             last_c;
  logic             commit_c;

  // Decode of the latched request: fault check, load extraction, store lanes.
  always_comb begin
    idx_c     = addr_q[IDX_W+1:2];
    word_c    = mem[idx_c];
    byte_c    = word_c[{addr_q[1:0], 3'b000} +: 8];
    half_c    = word_c[{addr_q[1], 4'b0000} +: 16];
    acc_err_c = 1'b0;
    ld_data_c = word_c;
    be_c      = 4'b0000;
    wr_data_c = wdata_q;

    case (f3_q)
      F3_B, F3_BU: acc_err_c = 1'b0;
      F3_H, F3_HU: acc_err_c = addr_q[0];
      F3_W:        acc_err_c = (addr_q[1:0] != 2'b00);
      default:     acc_err_c = 1'b1;
    endcase
    if (we_q && (f3_q == F3_BU || f3_q == F3_HU)) acc_err_c = 1'b1;
    if ({2'b00, addr_q[31:2]} >= DEPTH_WORDS)     acc_err_c = 1'b1;

    case (f3_q)
      F3_B:    ld_data_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   ld_data_c = {24'h000000, byte_c};
      F3_H:    ld_data_c = {{16{half_c[15]}}, half_c};
      F3_HU:   ld_data_c = {16'h0000, half_c};
      default: ld_data_c = word_c;
    endcase

    // Replicate store data so every enabled lane sees its own byte.
    case (f3_q)
      F3_B: begin
        be_c      = 4'b0001 << addr_q[1:0];
        wr_data_c = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        be_c      = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data_c = {2{wdata_q[15:0]}};
      end
      F3_W: begin
        be_c      = 4'b1111;
        wr_data_c = wdata_q;
      end
      default: begin
        be_c      = 4'b0000;
        wr_data_c = wdata_q;
      end
    endcase

    last_c   = (state_q == ACCESS) && (cnt_q == '0);
    commit_c = last_c && we_q && !acc_err_c && !RST;
  end

  // Next-state and registered outputs; synchronous reset overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID && req_ready_q) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(LATENCY - 1);
          we_d    = bus.REQ_WE;
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          f3_d    = bus.REQ_FUNCT3;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = acc_err_c;
          rdata_d = (acc_err_c || we_q) ? 32'h0000_0000 : ld_data_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (RST) begin
      state_d = IDLE;
      cnt_d   = '0;
      we_d    = 1'b0;
      addr_d  = 32'h0000_0000;
      wdata_d = 32'h0000_0000;
      f3_d    = 3'b000;
      rdata_d = 32'h0000_0000;
      err_d   = 1'b0;
    end

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    we_q        <= we_d;
    addr_q      <= addr_d;
    wdata_q     <= wdata_d;
    f3_q        <= f3_d;
    rdata_q     <= rdata_d;
    err_q       <= err_d;
    req_ready_q <= req_ready_d;
    rsp_valid_q <= rsp_valid_d;
  end

  // Storage is never reset; stores land only on the final ACCESS edge.
  always_ff @(posedge CLK) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;
endmodule
